bcd_encode_scheduler: RTL and testbench

Shares one bcd_encoder instance among NUM_REQ requesters using round-robin arbitration and a four-phase req/ack handshake. The granted requester's 4-bit binary operand is latched and applied to the encoder for one cycle. The 8-bit two-digit BCD result is then registered and returned with the winner's ID. The block sits between per-channel display/formatting logic and the single shared encoder datapath.

---
 rtl/bcd_pkg.sv | 13 +
 rtl/bcd_encoder.sv | 19 +
 rtl/bcd_rr_arbiter.sv | 38 +++
 rtl/bcd_encode_scheduler.sv | 119 +++++++++++
 tb/tb_bcd_encode_scheduler.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD encode scheduler: controller states and
// BCD digit geometry.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    ACK  = 2'd2
  } state_e;

endpackage : bcd_pkg

// File: rtl/bcd_encoder.sv
// Combinational 4-bit binary to two-digit BCD encoder, Y = {tens, ones}.
module bcd_encoder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0]   Q,
  output logic [2*DIGIT_W-1:0] Y
);

  // Values 10..15 carry one ten; the ones digit is the remainder.
  always_comb begin
    Y = '0;
    if (Q > 4'd9) begin
      Y = {4'd1, Q - 4'd10};
    end else begin
      Y = {4'd0, Q};
    end
  end

endmodule : bcd_encoder

// File: rtl/bcd_rr_arbiter.sv
// Combinational round-robin arbiter: first set request searching upward from
// ptr_i with wrap-around, returned as one-hot grant and binary index.
module bcd_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o
);

  // Walk the requesters in priority order starting at the pointer.
  always_comb begin
    logic found;
    int   cand;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr_i) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end else begin
        cand = cand;
      end
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = ID_W'(cand);
      end else begin
        found = found;
      end
    end
  end

endmodule : bcd_rr_arbiter

// File: rtl/bcd_encode_scheduler.sv
// Round-robin scheduler sharing one bcd_encoder among NUM_REQ requesters via
// a four-phase req/ack handshake; all outputs are registered.
module bcd_encode_scheduler
  import bcd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [4*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic [2*DIGIT_W-1:0]   result,
  output logic [ID_W-1:0]        result_id,
  output logic                   busy
);

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [DIGIT_W-1:0]     operand_q, operand_d;
  logic [2*DIGIT_W-1:0]   result_q, result_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic                   busy_q, busy_d;

  logic [NUM_REQ-1:0]     arb_grant;
  logic [ID_W-1:0]        arb_idx;
  logic [2*DIGIT_W-1:0]   enc_y;

  bcd_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx)
  );

  bcd_encoder u_enc (
    .Q (operand_q),
    .Y (enc_y)
  );

  // Controller next-state: grant in IDLE, encode for one cycle, then hold
  // the acknowledge until the winner drops its request.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    operand_d = operand_q;
    result_d  = result_q;
    ack_d     = ack_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (|arb_grant) begin
          state_d   = ENC;
          id_d      = arb_idx;
          operand_d = req_data[4*int'(arb_idx) +: DIGIT_W];
          busy_d    = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      ENC: begin
        state_d      = ACK;
        result_d     = enc_y;
        ack_d        = '0;
        ack_d[id_q]  = 1'b1;
        busy_d       = 1'b1;
      end
      ACK: begin
        if (!req[id_q]) begin
          state_d  = IDLE;
          ack_d    = '0;
          busy_d   = 1'b0;
          rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
        end else begin
          state_d = ACK;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      id_q      <= '0;
      operand_q <= '0;
      result_q  <= 8'h00;
      ack_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      operand_q <= operand_d;
      result_q  <= result_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign result    = result_q;
  assign result_id = id_q;
  assign busy      = busy_q;

endmodule : bcd_encode_scheduler

// File: tb/tb_bcd_encode_scheduler.sv
// Directed, table-driven bench for bcd_encode_scheduler with NUM_REQ = 4.
module tb_bcd_encode_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  ack;
  logic [7:0]  result;
  logic [1:0]  result_id;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         idx;
    logic [3:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t       all4_tbl [4];
  logic [7:0] sweep_exp [16];
  int         fair_exp [4];

  bcd_encode_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .result    (result),
    .result_id (result_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (|ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin : main
    bit ok;
    int id;
    int ack_cycles;

    all4_tbl[0] = '{0, 4'd3,  8'h03};
    all4_tbl[1] = '{1, 4'd9,  8'h09};
    all4_tbl[2] = '{2, 4'd10, 8'h10};
    all4_tbl[3] = '{3, 4'd15, 8'h15};
    sweep_exp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                  8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    fair_exp = '{1, 3, 1, 3};

    // 1: reset held with every request pending
    rst_n    = 1'b0;
    req      = 4'b1111;
    req_data = 16'h4321;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_result", 32'(result), 32'h00);
    end
    rst_n = 1'b1;
    wait_ack(ok);
    chk("t1_ackseen", 32'(ok), 32'h1);
    chk("t1_first_id", 32'(result_id), 32'h0);
    chk("t1_first_res", 32'(result), 32'h01);
    req = 4'b0000;
    tick();
    tick();

    // 2: single requester, exact latency
    req_data[11:8] = 4'd13;
    req[2] = 1'b1;
    tick();
    chk("t2_busy_enc", 32'(busy), 32'h1);
    chk("t2_ack_enc", 32'(ack), 32'h0);
    tick();
    chk("t2_ack", 32'(ack), 32'h4);
    chk("t2_res", 32'(result), 32'h13);
    chk("t2_id", 32'(result_id), 32'h2);
    req[2] = 1'b0;
    tick();
    chk("t2_ack_drop", 32'(ack), 32'h0);
    chk("t2_busy_drop", 32'(busy), 32'h0);
    chk("t2_res_hold", 32'(result), 32'h13);

    // 3: all four at once after reset -> service order 0..3
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) req_data[4*all4_tbl[i].idx +: 4] = all4_tbl[i].op;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ack(ok);
      chk("t3_ackseen", 32'(ok), 32'h1);
      chk("t3_id", 32'(result_id), 32'(all4_tbl[i].idx));
      chk("t3_res", 32'(result), 32'(all4_tbl[i].exp));
      req[result_id] = 1'b0;
      tick();
      chk("t3_ack_drop", 32'(ack), 32'h0);
    end

    // 4: fairness between a greedy requester 1 and requester 3
    req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      wait_ack(ok);
      chk("t4_ackseen", 32'(ok), 32'h1);
      chk("t4_id", 32'(result_id), 32'(fair_exp[i]));
      id = int'(result_id);
      req[id] = 1'b0;
      tick();
      req[id] = 1'b1;
    end
    req = 4'b0000;
    tick();
    tick();
    tick();
    chk("t4_idle", 32'(busy), 32'h0);

    // 5: req[0] dropped during ENC, operand changed after grant
    req_data[3:0]  = 4'd7;
    req_data[11:8] = 4'd5;
    req = 4'b0101;
    tick();
    chk("t5_busy", 32'(busy), 32'h1);
    req[0] = 1'b0;
    req_data[3:0] = 4'd2;
    ack_cycles = 0;
    tick();
    chk("t5_ack0", 32'(ack), 32'h1);
    chk("t5_res", 32'(result), 32'h07);
    if (ack[0]) ack_cycles++;
    tick();
    if (ack[0]) ack_cycles++;
    chk("t5_ack_one_cycle", 32'(ack_cycles), 32'h1);
    chk("t5_idle", 32'(busy), 32'h0);
    tick();
    chk("t5_next_busy", 32'(busy), 32'h1);
    tick();
    chk("t5_next_ack", 32'(ack), 32'h4);
    chk("t5_next_res", 32'(result), 32'h05);
    req[2] = 1'b0;
    tick();

    // 6: asynchronous reset during ACK, then operand sweep
    req_data[7:4] = 4'd12;
    req[1] = 1'b1;
    wait_ack(ok);
    chk("t6_ack", 32'(ack), 32'h2);
    chk("t6_res", 32'(result), 32'h12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_ack", 32'(ack), 32'h0);
    chk("t6_async_busy", 32'(busy), 32'h0);
    chk("t6_async_res", 32'(result), 32'h00);
    req = 4'b0000;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_data[3:0] = 4'(i);
      req[0] = 1'b1;
      wait_ack(ok);
      chk("t6_ackseen", 32'(ok), 32'h1);
      chk("t6_sweep_res", 32'(result), 32'(sweep_exp[i]));
      chk("t6_sweep_id", 32'(result_id), 32'h0);
      req[0] = 1'b0;
      tick();
      chk("t6_sweep_drop", 32'(ack), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bcd_encode_scheduler
